crc16_frame_ctrl: RTL and testbench

- Frame-level sequencer for the crc16 byte-update engine.
- Accepts a byte stream with valid/ready/last and forwards each byte unchanged to an output stream.
- Drives the engine's init/en/data, then appends the 2-byte CRC (high byte first) after the last input byte.
- Sits between the AXI-Stream-style byte source and the link transmitter; seed is configured from the register block.

---
 rtl/crc16_pkg.sv | 32 +++
 rtl/crc16_frame_ctrl_engine.sv | 31 +++
 rtl/crc16_frame_ctrl.sv | 121 ++++++++++++
 tb/tb_crc16_frame_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc16_pkg.sv
// crc16_pkg
//   Shared definitions for the crc16 frame controller and its byte-update
//   engine: data widths, the frame-sequencer state encoding and the golden
//   CRC-16/CCITT (poly 0x1021, MSB-first, no reflection) byte update.
package crc16_pkg;

    localparam int CRC_W  = 16;
    localparam int BYTE_W = 8;

    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        CRC_HI = 2'd2,
        CRC_LO = 2'd3
    } state_t;

    // Folds one byte into the running CRC, most significant bit first.
    function automatic logic [CRC_W-1:0] crc16_update(
        input logic [CRC_W-1:0]  crc,
        input logic [BYTE_W-1:0] data
    );
        logic [CRC_W-1:0] c;
        c = crc ^ {data, {(CRC_W-BYTE_W){1'b0}}};
        for (int i = 0; i < BYTE_W; i++) begin
            c = c[CRC_W-1] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_frame_ctrl_engine.sv
// crc16_frame_ctrl_engine
//   Byte-at-a-time CRC-16 register. Loads the zero-extended seed on reset or
//   init, otherwise folds in one byte per cycle when en is high.
//   Ports:
//     clk, nrst      clock, synchronous active-low reset
//     seed  [7:0]    seed, loaded zero-extended to 16 bits
//     init           reload the seed
//     en             fold data into the CRC
//     data  [7:0]    byte to fold
//     crc   [15:0]   current CRC value
module crc16_frame_ctrl_engine
    import crc16_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic [BYTE_W-1:0] seed,
    input  logic              init,
    input  logic              en,
    input  logic [BYTE_W-1:0] data,
    output logic [CRC_W-1:0]  crc
);

    always_ff @(posedge clk) begin
        if (!nrst || init) begin
            crc <= {{(CRC_W-BYTE_W){1'b0}}, seed};
        end else if (en) begin
            crc <= crc16_update(crc, data);
        end
    end

endmodule

// File: rtl/crc16_frame_ctrl.sv
// crc16_frame_ctrl
//   Frame sequencer around the crc16 byte engine. Forwards each payload byte
//   unchanged through a single output register, then appends the frame CRC
//   high byte first, marking the low byte with out_last.
//   Ports:
//     clk, nrst          clock, synchronous active-low reset
//     cfg_seed [7:0]     CRC seed, taken at reset and at each frame re-init
//     abort              single-cycle request to drop the current frame
//     in_data/in_valid/in_last/in_ready   input byte stream
//     out_data/out_valid/out_last/out_ready  output byte stream
//     busy               sequencer not idle
//     frames_done        frames whose CRC low byte was loaded (wraps)
//     frames_aborted     aborts taken while busy (wraps)
//
//   state  | meaning
//   IDLE   | waiting for the first payload byte, engine holds the seed
//   DATA   | inside a frame, forwarding payload bytes
//   CRC_HI | payload done, loading crc[15:8] when the output is free
//   CRC_LO | loading crc[7:0] with out_last, then re-init the engine
module crc16_frame_ctrl
    import crc16_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [BYTE_W-1:0] cfg_seed,
    input  logic              abort,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  frames_done,
    output logic [CNT_W-1:0]  frames_aborted
);

    state_t           state;
    logic [CRC_W-1:0] crc;
    logic             free;
    logic             accept;
    logic             abort_taken;
    logic             crc_hi_load;
    logic             crc_lo_load;
    logic             eng_init;

    assign free        = !out_valid || out_ready;
    assign in_ready    = free && ((state == IDLE) || (state == DATA)) && !abort;
    assign accept      = in_valid && in_ready;
    assign abort_taken = abort && (state != IDLE);
    assign crc_hi_load = (state == CRC_HI) && free && !abort;
    assign crc_lo_load = (state == CRC_LO) && free && !abort;
    assign busy        = (state != IDLE);

    // Abort re-inits even when idle; accept is masked by abort, so en and
    // init can never be high together.
    assign eng_init = abort || crc_lo_load;

    crc16_frame_ctrl_engine u_engine (
        .clk  (clk),
        .nrst (nrst),
        .seed (cfg_seed),
        .init (eng_init),
        .en   (accept),
        .data (in_data),
        .crc  (crc)
    );

    always_ff @(posedge clk) begin
        if (!nrst || abort_taken) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= in_last ? CRC_HI : DATA;
                DATA:    if (accept && in_last) state <= CRC_HI;
                CRC_HI:  if (crc_hi_load) state <= CRC_LO;
                CRC_LO:  if (crc_lo_load) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // On abort none of the loads fire, so a byte already presented simply
    // drains through the last branch.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
        end else if (crc_hi_load) begin
            out_data  <= crc[CRC_W-1:BYTE_W];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
        end else if (crc_lo_load) begin
            out_data  <= crc[BYTE_W-1:0];
            out_valid <= 1'b1;
            out_last  <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            frames_done    <= '0;
            frames_aborted <= '0;
        end else begin
            if (crc_lo_load) frames_done <= frames_done + 1'b1;
            if (abort_taken) frames_aborted <= frames_aborted + 1'b1;
        end
    end

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// tb_crc16_frame_ctrl
//   Scoreboard bench: stimulus pushes expected output bytes ({last, data})
//   into a queue, a monitor pops and compares on every output handshake.
module tb_crc16_frame_ctrl;
    import crc16_pkg::*;

    localparam int CNT_W = 16;

    logic              clk;
    logic              nrst;
    logic [BYTE_W-1:0] cfg_seed;
    logic              abort;
    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic              busy;
    logic [CNT_W-1:0]  frames_done;
    logic [CNT_W-1:0]  frames_aborted;

    crc16_frame_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .cfg_seed       (cfg_seed),
        .abort          (abort),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .busy           (busy),
        .frames_done    (frames_done),
        .frames_aborted (frames_aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       rand_ready = 1'b0;
    logic       ready_force = 1'b1;
    logic       b2b_watch = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // out_ready driver: random backpressure or a forced level.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Monitor: handshake compare, hold stability, busy after CRC low byte,
    // and the back-to-back gap between frames.
    initial begin
        logic       held_v;
        logic [8:0] held;
        logic [8:0] e;
        logic       armed;
        int         last_cyc;
        held_v   = 1'b0;
        held     = '0;
        armed    = 1'b0;
        last_cyc = 0;
        forever begin
            @(negedge clk);
            if (held_v && out_valid) check("hold_stable", 32'({out_last, out_data}), 32'(held));
            held_v = nrst && out_valid && !out_ready;
            held   = {out_last, out_data};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_byte: got %0h expected none", {out_last, out_data});
                end else begin
                    e = exp_q.pop_front();
                    check("out_byte", 32'({out_last, out_data}), 32'(e));
                    if (armed && b2b_watch) begin
                        check("b2b_gap", 32'(cyc - last_cyc), 32'd1);
                        armed = 1'b0;
                    end
                    if (out_last) begin
                        check("busy_after_lo", 32'(busy), 32'd0);
                        last_cyc = cyc;
                        armed    = b2b_watch;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int t;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 300) break;
        end
        if (t > 300) begin
            fail_now("send");
            @(posedge clk);
        end else begin
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (exp_q.size() != 0) begin
            fail_now("drain");
            exp_q.delete();
        end
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] crc;
        logic [7:0]  b;
        nrst     = 1'b0;
        cfg_seed = 8'h00;
        abort    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick(3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frames_done), 32'd0);
        check("rst_aborted", 32'(frames_aborted), 32'd0);
        nrst = 1'b1;
        tick(1);

        // Single-byte frame, seed 0: CRC(0x01) = 0x1021.
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h010);
        exp_q.push_back(9'h121);
        send(8'h01, 1'b1);
        drain();
        check("done_after_t1", 32'(frames_done), 32'd1);

        // CRC(0x10) = 0x1231, then CRC(0x00) = 0x0000 shows the re-init.
        exp_q.push_back(9'h010);
        exp_q.push_back(9'h012);
        exp_q.push_back(9'h131);
        send(8'h10, 1'b1);
        exp_q.push_back(9'h000);
        exp_q.push_back(9'h000);
        exp_q.push_back(9'h100);
        send(8'h00, 1'b1);
        drain();
        check("done_after_t2", 32'(frames_done), 32'd3);

        // 64-byte random frame with backpressure; seed changes mid-frame and
        // must not affect this frame's CRC.
        rand_ready = 1'b1;
        crc = 16'h0000;
        for (int i = 0; i < 64; i++) begin
            b   = 8'($urandom);
            crc = crc16_update(crc, b);
            exp_q.push_back({1'b0, b});
            if (i == 20) cfg_seed = 8'hA5;
            send(b, (i == 63));
        end
        exp_q.push_back({1'b0, crc[15:8]});
        exp_q.push_back({1'b1, crc[7:0]});
        drain();
        rand_ready = 1'b0;
        tick(2);
        check("done_after_rand", 32'(frames_done), 32'd4);

        // Back-to-back frames, in_valid held, engine re-seeded with 0xA5.
        b2b_watch = 1'b1;
        for (int f = 0; f < 2; f++) begin
            crc = 16'h00A5;
            for (int i = 0; i < 3; i++) begin
                b   = 8'($urandom);
                crc = crc16_update(crc, b);
                exp_q.push_back({1'b0, b});
                send(b, (i == 2));
            end
            exp_q.push_back({1'b0, crc[15:8]});
            exp_q.push_back({1'b1, crc[7:0]});
        end
        drain();
        b2b_watch = 1'b0;
        check("done_after_b2b", 32'(frames_done), 32'd6);

        // Abort while idle: re-init to seed 0, counters unchanged.
        cfg_seed = 8'h00;
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(1);
        check("idle_abort_cnt", 32'(frames_aborted), 32'd0);

        // Abort after 3 payload bytes: no CRC, next frame uses seed 0.
        exp_q.push_back(9'h011);
        exp_q.push_back(9'h022);
        exp_q.push_back(9'h033);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(3);
        check("aborted_cnt", 32'(frames_aborted), 32'd1);
        check("busy_after_abort", 32'(busy), 32'd0);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h010);
        exp_q.push_back(9'h121);
        send(8'h01, 1'b1);
        drain();
        check("done_after_abort", 32'(frames_done), 32'd7);
        check("aborted_final", 32'(frames_aborted), 32'd1);

        // Reset while stuck in CRC_HI under backpressure.
        cfg_seed    = 8'h5A;
        ready_force = 1'b0;
        tick(2);
        send(8'h01, 1'b1);
        tick(2);
        check("stuck_busy", 32'(busy), 32'd1);
        check("stuck_valid", 32'(out_valid), 32'd1);
        nrst = 1'b0;
        tick(1);
        nrst = 1'b1;
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_done", 32'(frames_done), 32'd0);
        check("rst2_aborted", 32'(frames_aborted), 32'd0);
        ready_force = 1'b1;
        tick(2);
        // Engine reloaded 0x005A; CRC(0x00) from there = 0x5A00.
        exp_q.push_back(9'h000);
        exp_q.push_back(9'h05A);
        exp_q.push_back(9'h100);
        send(8'h00, 1'b1);
        drain();
        check("done_after_rst2", 32'(frames_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
